// File: rtl/pipe_issue_pkg.sv
// rtl/pipe_issue_pkg.sv - shared widths, field offsets, FSM encoding and instruction unpack helper
package pipe_issue_pkg;

  localparam int REG_W   = 4;
  localparam int FUNC_W  = 4;
  localparam int ADDR_W  = 8;
  localparam int INSTR_W = 24;

  // Field offsets inside one 24-bit instruction word {rs1,rs2,rd,func,addr}
  localparam int ADDR_LSB = 0;
  localparam int FUNC_LSB = ADDR_LSB + ADDR_W;
  localparam int RD_LSB   = FUNC_LSB + FUNC_W;
  localparam int RS2_LSB  = RD_LSB + REG_W;
  localparam int RS1_LSB  = RS2_LSB + REG_W;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  typedef struct packed {
    logic [REG_W-1:0]  rs1;
    logic [REG_W-1:0]  rs2;
    logic [REG_W-1:0]  rd;
    logic [FUNC_W-1:0] func;
    logic [ADDR_W-1:0] addr;
  } instr_t;

  function automatic instr_t unpack_instr(input logic [INSTR_W-1:0] raw);
    instr_t r;
    r.rs1  = raw[RS1_LSB  +: REG_W];
    r.rs2  = raw[RS2_LSB  +: REG_W];
    r.rd   = raw[RD_LSB   +: REG_W];
    r.func = raw[FUNC_LSB +: FUNC_W];
    r.addr = raw[ADDR_LSB +: ADDR_W];
    return r;
  endfunction

endpackage

// File: rtl/pipe_rr_arb2.sv
// rtl/pipe_rr_arb2.sv - two-way round-robin arbiter with internal priority pointer
module pipe_rr_arb2 (
  input  logic       clk1,
  input  logic       rst,
  input  logic [1:0] eligible,
  output logic [1:0] grant
);

  logic ptr;

  // Single grant: a lone eligible side wins, a tie goes to the pointer side
  always_comb begin
    grant = 2'b00;
    case (eligible)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = ptr ? 2'b10 : 2'b01;
      default: grant = 2'b00;
    endcase
  end

  // Pointer moves to the side that did not win; idle cycles leave it alone
  always_ff @(posedge clk1) begin
    if (rst) begin
      ptr <= 1'b0;
    end else if (grant[0]) begin
      ptr <= 1'b1;
    end else if (grant[1]) begin
      ptr <= 1'b0;
    end
  end

endmodule

// File: rtl/pipe_issue_ctrl.sv
// rtl/pipe_issue_ctrl.sv - RAW-aware two-source issue controller with flush/drain; PIPE_ISSUE_STATS_EN adds grant/stall counters
module pipe_issue_ctrl
  import pipe_issue_pkg::*;
#(
  parameter int WB_LAT = 3,
  parameter int NREG   = 16
) (
  input  logic                 clk1,
  input  logic                 rst,
  input  logic [1:0]           req_valid,
  input  logic [2*INSTR_W-1:0] req_instr,
  output logic [1:0]           req_ready,
  input  logic                 flush_req,
  output logic                 iss_valid,
  output logic [REG_W-1:0]     iss_rs1,
  output logic [REG_W-1:0]     iss_rs2,
  output logic [REG_W-1:0]     iss_rd,
  output logic [FUNC_W-1:0]    iss_func,
  output logic [ADDR_W-1:0]    iss_addr,
  output logic [NREG-1:0]      busy_mask,
  output logic                 drained
`ifdef PIPE_ISSUE_STATS_EN
  ,
  output logic [15:0]          stat_issued,
  output logic [15:0]          stat_stall
`endif
);

  state_t state_q;
  state_t state_d;
  logic   issue_allow;

  instr_t req_fld [2];
  instr_t sel_fld;

  logic [WB_LAT-1:0] sb_v;
  logic [REG_W-1:0]  sb_rd [WB_LAT];
  logic              sb_empty;

  logic [1:0] hazard;
  logic [1:0] eligible;
  logic [1:0] grant;
  logic       grant_any;

  // Split the two packed request words into fields
  always_comb begin
    req_fld[0] = unpack_instr(req_instr[INSTR_W-1:0]);
    req_fld[1] = unpack_instr(req_instr[2*INSTR_W-1:INSTR_W]);
  end

  // RAW check: either source operand matches a destination still in flight
  always_comb begin
    hazard = 2'b00;
    for (int i = 0; i < 2; i++) begin
      for (int j = 0; j < WB_LAT; j++) begin
        if (sb_v[j] && ((sb_rd[j] == req_fld[i].rs1) || (sb_rd[j] == req_fld[i].rs2))) begin
          hazard[i] = 1'b1;
        end
      end
    end
  end

  assign sb_empty = ~|sb_v;

  // FSM state register
  always_ff @(posedge clk1) begin
    if (rst) begin
      state_q <= ST_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state: flush drains the scoreboard, release of flush resumes issue
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN:   if (flush_req) state_d = ST_DRAIN;
      ST_DRAIN: if (sb_empty)  state_d = ST_DONE;
      ST_DONE:  if (!flush_req) state_d = ST_RUN;
      default:  state_d = ST_RUN;
    endcase
  end

  // FSM outputs: flush blocks acceptance in the very cycle it is raised
  always_comb begin
    issue_allow = (state_q == ST_RUN) && !flush_req && !rst;
    drained     = (state_q == ST_DONE);
  end

  assign eligible = issue_allow ? (req_valid & ~hazard) : 2'b00;

  pipe_rr_arb2 u_arb (
    .clk1     (clk1),
    .rst      (rst),
    .eligible (eligible),
    .grant    (grant)
  );

  assign req_ready = grant;
  assign grant_any = |grant;
  assign sel_fld   = grant[1] ? req_fld[1] : req_fld[0];

  // Issue register: load the granted instruction, hold fields while idle
  always_ff @(posedge clk1) begin
    if (rst) begin
      iss_valid <= 1'b0;
      iss_rs1   <= '0;
      iss_rs2   <= '0;
      iss_rd    <= '0;
      iss_func  <= '0;
      iss_addr  <= '0;
    end else begin
      iss_valid <= grant_any;
      if (grant_any) begin
        iss_rs1  <= sel_fld.rs1;
        iss_rs2  <= sel_fld.rs2;
        iss_rd   <= sel_fld.rd;
        iss_func <= sel_fld.func;
        iss_addr <= sel_fld.addr;
      end
    end
  end

  // Scoreboard shift register: entry 0 mirrors the issue register, ages out after WB_LAT cycles
  always_ff @(posedge clk1) begin
    if (rst) begin
      sb_v <= '0;
      for (int j = 0; j < WB_LAT; j++) sb_rd[j] <= '0;
    end else begin
      sb_v[0]  <= grant_any;
      sb_rd[0] <= sel_fld.rd;
      for (int j = 1; j < WB_LAT; j++) begin
        sb_v[j]  <= sb_v[j-1];
        sb_rd[j] <= sb_rd[j-1];
      end
    end
  end

  // One-hot OR of every valid in-flight destination
  always_comb begin
    busy_mask = '0;
    for (int j = 0; j < WB_LAT; j++) begin
      if (sb_v[j]) busy_mask[sb_rd[j]] = 1'b1;
    end
  end

`ifdef PIPE_ISSUE_STATS_EN
  // Saturating counters of grants and of RUN cycles where a request went unserved
  always_ff @(posedge clk1) begin
    if (rst) begin
      stat_issued <= '0;
      stat_stall  <= '0;
    end else begin
      if (grant_any && (stat_issued != 16'hFFFF)) begin
        stat_issued <= stat_issued + 16'd1;
      end
      if ((state_q == ST_RUN) && (|req_valid) && !grant_any && (stat_stall != 16'hFFFF)) begin
        stat_stall <= stat_stall + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_pipe_issue_ctrl.sv
// tb/tb_pipe_issue_ctrl.sv - table-driven bench for pipe_issue_ctrl plus reset/stats sequence
module tb_pipe_issue_ctrl;

  logic        clk1 = 1'b0;
  logic        rst;
  logic [1:0]  req_valid;
  logic [47:0] req_instr;
  logic [1:0]  req_ready;
  logic        flush_req;
  logic        iss_valid;
  logic [3:0]  iss_rs1, iss_rs2, iss_rd, iss_func;
  logic [7:0]  iss_addr;
  logic [15:0] busy_mask;
  logic        drained;
`ifdef PIPE_ISSUE_STATS_EN
  logic [15:0] stat_issued;
  logic [15:0] stat_stall;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk1 = ~clk1;

  pipe_issue_ctrl #(.WB_LAT(3), .NREG(16)) dut (
    .clk1      (clk1),
    .rst       (rst),
    .req_valid (req_valid),
    .req_instr (req_instr),
    .req_ready (req_ready),
    .flush_req (flush_req),
    .iss_valid (iss_valid),
    .iss_rs1   (iss_rs1),
    .iss_rs2   (iss_rs2),
    .iss_rd    (iss_rd),
    .iss_func  (iss_func),
    .iss_addr  (iss_addr),
    .busy_mask (busy_mask),
    .drained   (drained)
`ifdef PIPE_ISSUE_STATS_EN
    ,
    .stat_issued (stat_issued),
    .stat_stall  (stat_stall)
`endif
  );

  typedef struct {
    logic        rst;
    logic [1:0]  valid;
    logic [23:0] i0;
    logic [23:0] i1;
    logic        flush;
    logic [1:0]  ready;
    logic        iv;
    logic [23:0] iss;
    logic [15:0] busy;
    logic        dr;
  } vec_t;

  localparam int NV = 23;
  vec_t tv [NV];

  function automatic logic [23:0] ins(input logic [3:0] s1, input logic [3:0] s2,
                                      input logic [3:0] d, input logic [3:0] f,
                                      input logic [7:0] ad);
    return {s1, s2, d, f, ad};
  endfunction

  function automatic vec_t mk(input logic r, input logic [1:0] v, input logic [23:0] a,
                              input logic [23:0] b, input logic fl, input logic [1:0] rdy,
                              input logic ivl, input logic [23:0] is, input logic [15:0] bm,
                              input logic d);
    vec_t x;
    x.rst = r; x.valid = v; x.i0 = a; x.i1 = b; x.flush = fl;
    x.ready = rdy; x.iv = ivl; x.iss = is; x.busy = bm; x.dr = d;
    return x;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic [1:0] v, input logic [23:0] a,
                       input logic [23:0] b, input logic fl);
    rst = r; req_valid = v; req_instr = {b, a}; flush_req = fl;
    #1;
  endtask

  task automatic tick();
    @(posedge clk1);
    #1;
  endtask

  logic [23:0] ia, ib, ic, id, ie, i_f, ig, z;

  initial begin
    z   = 24'h0;
    ia  = ins(4'd6, 4'd1, 4'd10, 4'd2, 8'd125);
    ib  = ins(4'd10, 4'd8, 4'd12, 4'd3, 8'd126);
    ic  = ins(4'd1, 4'd2, 4'd3, 4'd0, 8'h11);
    id  = ins(4'd1, 4'd2, 4'd4, 4'd1, 8'h20);
    ie  = ins(4'd1, 4'd2, 4'd5, 4'd1, 8'h30);
    i_f = ins(4'd5, 4'd0, 4'd6, 4'd1, 8'h40);
    ig  = ins(4'd1, 4'd2, 4'd13, 4'd0, 8'h50);

    //           rst valid  i0   i1  fl  ready  iv  iss    busy      dr
    tv[0]  = mk(1, 2'b11, ia,  ia, 0, 2'b00, 0, z,  16'h0000, 0);
    tv[1]  = mk(0, 2'b01, ia,  z,  0, 2'b01, 0, z,  16'h0000, 0);
    tv[2]  = mk(0, 2'b01, ib,  z,  0, 2'b00, 1, ia, 16'h0400, 0);
    tv[3]  = mk(0, 2'b01, ib,  z,  0, 2'b00, 0, ia, 16'h0400, 0);
    tv[4]  = mk(0, 2'b01, ib,  z,  0, 2'b00, 0, ia, 16'h0400, 0);
    tv[5]  = mk(0, 2'b01, ib,  z,  0, 2'b01, 0, ia, 16'h0000, 0);
    tv[6]  = mk(0, 2'b10, ib,  ic, 0, 2'b10, 1, ib, 16'h1000, 0);
    tv[7]  = mk(0, 2'b11, id,  ie, 0, 2'b01, 1, ic, 16'h1008, 0);
    tv[8]  = mk(0, 2'b11, id,  ie, 0, 2'b10, 1, id, 16'h1018, 0);
    tv[9]  = mk(0, 2'b11, id,  ie, 0, 2'b01, 1, ie, 16'h0038, 0);
    tv[10] = mk(0, 2'b11, id,  ie, 0, 2'b10, 1, id, 16'h0030, 0);
    tv[11] = mk(0, 2'b11, i_f, ie, 0, 2'b10, 1, ie, 16'h0030, 0);
    tv[12] = mk(0, 2'b11, i_f, ie, 0, 2'b10, 1, ie, 16'h0030, 0);
    tv[13] = mk(0, 2'b11, i_f, ie, 0, 2'b10, 1, ie, 16'h0020, 0);
    tv[14] = mk(0, 2'b10, i_f, ig, 0, 2'b10, 1, ie, 16'h0020, 0);
    tv[15] = mk(0, 2'b01, id,  ig, 1, 2'b00, 1, ig, 16'h2020, 0);
    tv[16] = mk(0, 2'b11, id,  ie, 1, 2'b00, 0, ig, 16'h2020, 0);
    tv[17] = mk(0, 2'b11, id,  ie, 1, 2'b00, 0, ig, 16'h2000, 0);
    tv[18] = mk(0, 2'b11, id,  ie, 1, 2'b00, 0, ig, 16'h0000, 0);
    tv[19] = mk(0, 2'b11, id,  ie, 1, 2'b00, 0, ig, 16'h0000, 1);
    tv[20] = mk(0, 2'b01, id,  ie, 0, 2'b00, 0, ig, 16'h0000, 1);
    tv[21] = mk(0, 2'b01, id,  ie, 0, 2'b01, 0, ig, 16'h0000, 0);
    tv[22] = mk(0, 2'b00, id,  ie, 0, 2'b00, 1, id, 16'h0010, 0);

    drive(1'b1, 2'b11, z, z, 1'b0);
    tick();

    for (int k = 0; k < NV; k++) begin
      drive(tv[k].rst, tv[k].valid, tv[k].i0, tv[k].i1, tv[k].flush);
      chk($sformatf("row%0d req_ready", k), {30'd0, req_ready}, {30'd0, tv[k].ready});
      chk($sformatf("row%0d iss_valid", k), {31'd0, iss_valid}, {31'd0, tv[k].iv});
      chk($sformatf("row%0d iss_fields", k), {8'd0, iss_rs1, iss_rs2, iss_rd, iss_func, iss_addr},
          {8'd0, tv[k].iss});
      chk($sformatf("row%0d busy_mask", k), {16'd0, busy_mask}, {16'd0, tv[k].busy});
      chk($sformatf("row%0d drained", k), {31'd0, drained}, {31'd0, tv[k].dr});
      tick();
    end

    // Reset with a full scoreboard after 4 grants and 3 stalls
    drive(1'b1, 2'b00, z, z, 1'b0);
    tick();
    drive(1'b0, 2'b01, ins(4'd1, 4'd1, 4'd7, 4'd0, 8'h01), z, 1'b0);
    chk("seq c1 ready", {30'd0, req_ready}, 32'd1);
    tick();
    for (int c = 2; c <= 4; c++) begin
      drive(1'b0, 2'b01, ins(4'd7, 4'd7, 4'd8, 4'd0, 8'h02), z, 1'b0);
      chk($sformatf("seq c%0d stall ready", c), {30'd0, req_ready}, 32'd0);
      tick();
    end
    drive(1'b0, 2'b01, ins(4'd7, 4'd7, 4'd8, 4'd0, 8'h02), z, 1'b0);
    chk("seq c5 ready", {30'd0, req_ready}, 32'd1);
    tick();
    drive(1'b0, 2'b10, z, ins(4'd1, 4'd1, 4'd9, 4'd0, 8'h03), 1'b0);
    chk("seq c6 ready", {30'd0, req_ready}, 32'd2);
    tick();
    drive(1'b0, 2'b01, ins(4'd1, 4'd1, 4'd11, 4'd0, 8'h04), z, 1'b0);
    chk("seq c7 ready", {30'd0, req_ready}, 32'd1);
    tick();
    drive(1'b1, 2'b00, z, z, 1'b0);
    chk("seq full busy_mask", {16'd0, busy_mask}, 32'h0B00);
    chk("seq full iss_valid", {31'd0, iss_valid}, 32'd1);
`ifdef PIPE_ISSUE_STATS_EN
    chk("seq stat_issued", {16'd0, stat_issued}, 32'd4);
    chk("seq stat_stall", {16'd0, stat_stall}, 32'd3);
`endif
    tick();
    drive(1'b0, 2'b00, z, z, 1'b0);
    chk("post-rst busy_mask", {16'd0, busy_mask}, 32'd0);
    chk("post-rst iss_valid", {31'd0, iss_valid}, 32'd0);
    chk("post-rst iss_fields", {8'd0, iss_rs1, iss_rs2, iss_rd, iss_func, iss_addr}, 32'd0);
    chk("post-rst drained", {31'd0, drained}, 32'd0);
`ifdef PIPE_ISSUE_STATS_EN
    chk("post-rst stat_issued", {16'd0, stat_issued}, 32'd0);
    chk("post-rst stat_stall", {16'd0, stat_stall}, 32'd0);
`endif
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
